// File: rtl/jtag_tap_pkg.sv
// Shared TAP types and constants: state encoding, instruction codes and
// the IEEE 1149.1 next-state and instruction-decode helpers.
package jtag_tap_pkg;

  localparam int IR_WIDTH = 5;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 5'b00001;
  localparam logic [IR_WIDTH-1:0] IR_CONFREG = 5'b00110;
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 5'b11111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 5'b00101;

  typedef enum logic [3:0] {
    TLR        = 4'h0,
    RTI        = 4'h1,
    SELECT_DR  = 4'h2,
    CAPTURE_DR = 4'h3,
    SHIFT_DR   = 4'h4,
    EXIT1_DR   = 4'h5,
    PAUSE_DR   = 4'h6,
    EXIT2_DR   = 4'h7,
    UPDATE_DR  = 4'h8,
    SELECT_IR  = 4'h9,
    CAPTURE_IR = 4'hA,
    SHIFT_IR   = 4'hB,
    EXIT1_IR   = 4'hC,
    PAUSE_IR   = 4'hD,
    EXIT2_IR   = 4'hE,
    UPDATE_IR  = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_IDCODE  = 2'd0,
    SEL_CONFREG = 2'd1,
    SEL_BYPASS  = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    case (state)
      TLR:        nxt = tms ? TLR       : RTI;
      RTI:        nxt = tms ? SELECT_DR : RTI;
      SELECT_DR:  nxt = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: nxt = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   nxt = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   nxt = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  nxt = tms ? SELECT_DR : RTI;
      SELECT_IR:  nxt = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: nxt = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   nxt = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   nxt = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  nxt = tms ? SELECT_DR : RTI;
      default:    nxt = TLR;
    endcase
    return nxt;
  endfunction

  // Unknown opcodes fall back to BYPASS so the chain length stays defined.
  function automatic dr_sel_e decode_ir(input logic [IR_WIDTH-1:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_IDCODE:  sel = SEL_IDCODE;
      IR_CONFREG: sel = SEL_CONFREG;
      default:    sel = SEL_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the asynchronous JTAG pins into the clk_i domain and turns TCK
// into single-cycle rise/fall strobes aligned with the sampled TMS/TDI/TRST.
module jtag_pin_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  input  logic jtag_trst_n,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms,
  output logic tdi,
  output logic trst_n
);

  logic [2:0] tck_sync_r;
  logic [1:0] tms_sync_r;
  logic [1:0] tdi_sync_r;
  logic [1:0] trst_sync_r;

  // Two-flop synchronizers, third TCK stage for edge detect, registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync_r  <= 3'b000;
      tms_sync_r  <= 2'b11;
      tdi_sync_r  <= 2'b00;
      trst_sync_r <= 2'b00;
      tck_rise    <= 1'b0;
      tck_fall    <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      trst_n      <= 1'b0;
    end else begin
      tck_sync_r  <= {tck_sync_r[1:0], jtag_tck};
      tms_sync_r  <= {tms_sync_r[0], jtag_tms};
      tdi_sync_r  <= {tdi_sync_r[0], jtag_tdi};
      trst_sync_r <= {trst_sync_r[0], jtag_trst_n};
      tck_rise    <= tck_sync_r[1] & ~tck_sync_r[2];
      tck_fall    <= ~tck_sync_r[1] & tck_sync_r[2];
      tms         <= tms_sync_r[1];
      tdi         <= tdi_sync_r[1];
      trst_n      <= trst_sync_r[1];
    end
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Chip-side JTAG TAP oversampled in clk_i: 16-state FSM, 5-bit IR and
// IDCODE / BYPASS / CONFREG data registers.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0]           IDCODE_VALUE = 32'h249511C3,
  parameter int                    CONF_WIDTH   = 9,
  parameter logic [CONF_WIDTH-1:0] CONF_RESET   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jtag_tck_i,
  input  logic                  jtag_trst_ni,
  input  logic                  jtag_tms_i,
  input  logic                  jtag_tdi_i,
  output logic                  jtag_tdo_o,
  output logic                  jtag_tdo_oe_o,
  output logic [CONF_WIDTH-1:0] conf_reg_o,
  output logic                  conf_update_o,
  output logic [3:0]            tap_state_o
);

  logic tck_rise_s;
  logic tck_fall_s;
  logic tms_s;
  logic tdi_s;
  logic trst_n_s;

  tap_state_e          state_r;
  logic [IR_WIDTH-1:0] ir_r;
  logic [IR_WIDTH-1:0] ir_sr_r;
  logic [31:0]         dr_sr_r;
  dr_sel_e             dr_sel_s;
  logic [31:0]         dr_capture_s;
  logic [31:0]         dr_shift_s;

  jtag_pin_sync u_pin_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .jtag_tck    (jtag_tck_i),
    .jtag_tms    (jtag_tms_i),
    .jtag_tdi    (jtag_tdi_i),
    .jtag_trst_n (jtag_trst_ni),
    .tck_rise    (tck_rise_s),
    .tck_fall    (tck_fall_s),
    .tms         (tms_s),
    .tdi         (tdi_s),
    .trst_n      (trst_n_s)
  );

  assign dr_sel_s    = decode_ir(ir_r);
  assign tap_state_o = state_r;

  // Capture value and one-step shift of the shared DR, sized by the selected register.
  always_comb begin
    dr_shift_s = {1'b0, dr_sr_r[31:1]};
    case (dr_sel_s)
      SEL_IDCODE: begin
        dr_capture_s   = IDCODE_VALUE;
        dr_shift_s[31] = tdi_s;
      end
      SEL_CONFREG: begin
        dr_capture_s               = 32'(conf_reg_o);
        dr_shift_s[CONF_WIDTH-1]   = tdi_s;
      end
      default: begin
        dr_capture_s  = 32'd0;
        dr_shift_s[0] = tdi_s;
      end
    endcase
  end

  // TAP FSM with capture/shift on TCK rise and TDO/update on TCK fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= TLR;
      ir_r          <= IR_IDCODE;
      ir_sr_r       <= '0;
      dr_sr_r       <= 32'd0;
      conf_reg_o    <= CONF_RESET;
      conf_update_o <= 1'b0;
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else if (!trst_n_s) begin
      // conf_reg_o is deliberately left alone: TRST only resets the TAP itself.
      state_r       <= TLR;
      ir_r          <= IR_IDCODE;
      conf_update_o <= 1'b0;
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else begin
      conf_update_o <= 1'b0;
      if (tck_rise_s) begin
        state_r <= tap_next(state_r, tms_s);
        case (state_r)
          CAPTURE_IR: ir_sr_r <= IR_CAPTURE;
          SHIFT_IR:   ir_sr_r <= {tdi_s, ir_sr_r[IR_WIDTH-1:1]};
          CAPTURE_DR: dr_sr_r <= dr_capture_s;
          SHIFT_DR:   dr_sr_r <= dr_shift_s;
          default:    dr_sr_r <= dr_sr_r;
        endcase
      end else if (tck_fall_s) begin
        case (state_r)
          SHIFT_IR: begin
            jtag_tdo_o    <= ir_sr_r[0];
            jtag_tdo_oe_o <= 1'b1;
          end
          SHIFT_DR: begin
            jtag_tdo_o    <= dr_sr_r[0];
            jtag_tdo_oe_o <= 1'b1;
          end
          UPDATE_IR: begin
            ir_r          <= ir_sr_r;
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
          end
          UPDATE_DR: begin
            if (dr_sel_s == SEL_CONFREG) begin
              conf_reg_o    <= dr_sr_r[CONF_WIDTH-1:0];
              conf_update_o <= 1'b1;
            end else begin
              conf_update_o <= 1'b0;
            end
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
          end
          TLR: begin
            ir_r          <= IR_IDCODE;
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
          end
          default: begin
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
